text_cursor_ctrl: RTL and testbench
===================================

Name: text_cursor_ctrl

Overview:
- Write-side sequencer for the 32x28-cell character RAM behind the 512x448 tile display.
- Consumes received UART bytes as one-cycle strobes, maintains a text cursor, and interprets control codes.
- Issues single-cycle write commands on the RAM write port; runs multi-cycle line and screen clears.
- The video read port stays untouched; this block is the only writer.

Parameters:
- COLS, 32, columns per row; column field is 5 bits, address = {row[4:0], col[4:0]}.
- ROWS, 28, visible rows; rows 28..31 are never written.
- BLANK_CODE, 4'd10, glyph code rendered as an empty cell.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  asynchronous, active-low reset.
- rx_strobe  in  1  one-cycle pulse: rx_data is valid.
- rx_data  in  8  received byte (ASCII).
- clear_req  in  1  one-cycle pulse: clear screen and home the cursor (same effect as 0x0C).
- wr_en  out  1  RAM write enable, one cycle per cell.
- wr_addr  out  10  RAM write address {row, col}.
- wr_data  out  8  RAM write data; bits [7:4] are always 0.
- cur_row  out  5  cursor row, 0..ROWS-1.
- cur_col  out  5  cursor column, 0..COLS-1.
- busy  out  1  high while in CLR_LINE or CLR_SCR.
- overrun  out  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset (rst low, asynchronous): all outputs and registers go to 0, state = IDLE, pending buffer empty.
  - No RAM clear on reset.
  - Reset mid-clear aborts the clear immediately, leaving RAM partially cleared.
- Byte classes:
  - 0x30..0x39: PRINT with code = byte - 0x30.
  - 0x20: PRINT with BLANK_CODE.
  - 0x0D (CR): cur_col = 0.
  - 0x0A (LF): NEWLINE.
  - 0x08 (BS): if cur_col > 0, cur_col - 1, then write BLANK_CODE at the new position; at col 0, no action.
  - 0x0C (FF): CLEAR_SCREEN.
  - All other bytes are ignored (no write, no cursor change).
- PRINT:
  - Byte accepted in cycle N → wr_en = 1 in cycle N+1 with wr_addr = {cur_row, cur_col} (pre-increment) and wr_data = code.
  - Cursor advances in the same cycle N+1.
  - If cur_col was COLS-1, the advance performs NEWLINE.
- NEWLINE:
  - cur_col = 0; cur_row = (cur_row == ROWS-1) ? 0 : cur_row + 1 (wrap, no scroll).
  - Then enter CLR_LINE on the new row.
- States:
  - IDLE: processes a byte from the pending buffer first, otherwise rx_strobe directly.
  - CLR_LINE: wr_en = 1 for exactly COLS consecutive cycles, columns 0..31 of cur_row, wr_data = BLANK_CODE, then → IDLE. Cursor is not moved during the clear.
  - CLR_SCR: wr_en = 1 for exactly ROWS*COLS = 896 consecutive cycles, row-major from {0,0} to {27,31}. Cursor is forced to 0,0 on entry. → IDLE.
  - busy is high in CLR_LINE and CLR_SCR.
- Sequencing: the PRINT write that triggers a wrap occurs in cycle N+1; CLR_LINE writes occupy N+2..N+33.
- clear_req:
  - Accepted in any state; it has priority over a byte strobe in the same cycle (that byte goes to pending).
  - From CLR_LINE it aborts the line clear and enters CLR_SCR.
  - During CLR_SCR it restarts the sweep at {0,0}.
- Pending buffer (1 entry):
  - Any rx_strobe while busy, or coincident with clear_req, is latched.
  - A strobe arriving while pending is already full is dropped and overrun pulses 1 cycle after it; the existing pending entry is kept.
  - The pending byte is processed in the first IDLE cycle after busy falls; a new rx_strobe in that same cycle is latched as the next pending entry.
- At most one write is issued per cycle. wr_addr and wr_data hold their last value when wr_en = 0.
- Cursor arithmetic is 5-bit with explicit compares against COLS-1 / ROWS-1; no implicit overflow.

Decomposition:
- Shared package text_pkg: COLS, ROWS, BLANK_CODE, ASCII constants (CHR_CR, CHR_LF, CHR_BS, CHR_FF, CHR_SP, CHR_0), state enum {IDLE, CLR_LINE, CLR_SCR}.
- One natural sub-module, text_byte_decode: combinational byte → {class, glyph code}.
- FSM, cursor, and pending buffer stay in text_cursor_ctrl.

Test Plan:
- Reset, then strobe '5' (0x35) → one cycle later: wr_en = 1, wr_addr = 0x000, wr_data = 0x05; cur_col = 1.
- 32 × '1' from home → 32 writes at 0x000..0x01F. Then:
  - cur_row = 1, cur_col = 0, busy high for 32 cycles;
  - BLANK_CODE is written to 0x020..0x03F.
- Cursor at row 27, col 3; strobe 0x0A → cur_row = 0, cur_col = 0; 32 blank writes at 0x000..0x01F.
- Strobe 0x0C → 896 writes of 0x0A covering 0x000..0x37F, busy 896 cycles.
  - Two '7' strobes during the clear: the first is written at 0x000 after busy falls; the second pulses overrun and is never written.
- Cursor col 0, strobe 0x08 → no write, no change. At col 4: cur_col = 3, write 0x0A at {row, 3}.
- Assert rst low at cycle 100 of a CLR_SCR → wr_en = 0 and cursor 0,0 immediately; after release, a strobe of 'A' (0x41) → no write, no cursor change.

Source files
------------

// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants, byte classes and FSM states for the text cursor controller
package text_pkg;

  // Screen geometry; the address is {row[4:0], col[4:0]}
  localparam int COLS = 32;
  localparam int ROWS = 28;
  localparam logic [3:0] BLANK_CODE = 4'd10;

  localparam logic [4:0] COL_LAST = 5'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam logic [9:0] LINE_LAST = {5'd0, COL_LAST};
  localparam logic [9:0] SCR_LAST = 10'(ROWS * COLS - 1);

  // ASCII codes with special meaning
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_SP = 8'h20;
  localparam logic [7:0] CHR_0 = 8'h30;

  typedef enum logic [1:0] {
    IDLE,
    CLR_LINE,
    CLR_SCR
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_PRINT,
    CLS_CR,
    CLS_LF,
    CLS_BS,
    CLS_FF
  } byte_class_t;

endpackage

// File: rtl/text_byte_decode.sv
// rtl/text_byte_decode.sv - combinational byte to {class, glyph code} decoder
module text_byte_decode
  import text_pkg::*;
(
  input  logic [7:0]  data,
  output byte_class_t cls,
  output logic [3:0]  code
);

  // Digits map to their value (low nibble of 0x30..0x39); space maps to the blank glyph
  always_comb begin
    cls  = CLS_NONE;
    code = BLANK_CODE;
    if (data >= CHR_0 && data <= (CHR_0 + 8'd9)) begin
      cls  = CLS_PRINT;
      code = data[3:0];
    end else begin
      case (data)
        CHR_SP: cls = CLS_PRINT;
        CHR_CR: cls = CLS_CR;
        CHR_LF: cls = CLS_LF;
        CHR_BS: cls = CLS_BS;
        CHR_FF: cls = CLS_FF;
        default: cls = CLS_NONE;
      endcase
    end
  end

endmodule

// File: rtl/text_cursor_ctrl.sv
// rtl/text_cursor_ctrl.sv - character RAM write sequencer with cursor, control codes and clears
module text_cursor_ctrl
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_strobe,
  input  logic [7:0] rx_data,
  input  logic       clear_req,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [4:0] cur_row,
  output logic [4:0] cur_col,
  output logic       busy,
  output logic       overrun
);

  state_t      state, state_d;
  logic [9:0]  clr_idx, clr_idx_d;
  logic        pend_valid;
  logic [7:0]  pend_data;
  logic [4:0]  row_d, col_d;
  logic        wr_en_d;
  logic [9:0]  addr_d;
  logic [3:0]  code_d;

  logic        idle_free, proc_pend, take_direct, act_valid;
  logic        drop, latch_pend;
  logic [7:0]  act_byte;
  byte_class_t act_cls;
  logic [3:0]  act_code;
  logic [4:0]  row_next;
  logic        col_last;

  // A clear request claims the cycle, so bytes only act in IDLE without one
  assign idle_free   = (state == IDLE) && !clear_req;
  assign proc_pend   = idle_free && pend_valid;
  assign take_direct = idle_free && !pend_valid && rx_strobe;
  assign act_valid   = proc_pend || take_direct;
  assign act_byte    = pend_valid ? pend_data : rx_data;

  // A strobe that cannot act directly is parked, unless the slot stays occupied
  assign drop       = rx_strobe && pend_valid && !proc_pend;
  assign latch_pend = rx_strobe && !take_direct && !drop;

  assign row_next = (cur_row == ROW_LAST) ? 5'd0 : cur_row + 5'd1;
  assign col_last = (cur_col == COL_LAST);
  assign busy     = (state != IDLE);

  text_byte_decode u_decode (
    .data (act_byte),
    .cls  (act_cls),
    .code (act_code)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic and clear sweep index
  always_comb begin
    state_d   = state;
    clr_idx_d = clr_idx;
    if (clear_req) begin
      state_d   = CLR_SCR;
      clr_idx_d = 10'd0;
    end else begin
      case (state)
        IDLE: begin
          if (act_valid) begin
            case (act_cls)
              CLS_PRINT: begin
                if (col_last) begin
                  state_d   = CLR_LINE;
                  clr_idx_d = 10'd0;
                end
              end
              CLS_LF: begin
                state_d   = CLR_LINE;
                clr_idx_d = 10'd0;
              end
              CLS_FF: begin
                state_d   = CLR_SCR;
                clr_idx_d = 10'd0;
              end
              default: ;
            endcase
          end
        end
        CLR_LINE: begin
          if (clr_idx == LINE_LAST) begin
            state_d = IDLE;
          end else begin
            clr_idx_d = clr_idx + 10'd1;
          end
        end
        CLR_SCR: begin
          if (clr_idx == SCR_LAST) begin
            state_d = IDLE;
          end else begin
            clr_idx_d = clr_idx + 10'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: next cursor position and the write command for the coming cycle
  always_comb begin
    row_d   = cur_row;
    col_d   = cur_col;
    wr_en_d = 1'b0;
    addr_d  = wr_addr;
    code_d  = wr_data[3:0];
    if (clear_req) begin
      row_d = 5'd0;
      col_d = 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (act_valid) begin
            case (act_cls)
              CLS_PRINT: begin
                wr_en_d = 1'b1;
                addr_d  = {cur_row, cur_col};
                code_d  = act_code;
                if (col_last) begin
                  col_d = 5'd0;
                  row_d = row_next;
                end else begin
                  col_d = cur_col + 5'd1;
                end
              end
              CLS_CR: col_d = 5'd0;
              CLS_LF: begin
                col_d = 5'd0;
                row_d = row_next;
              end
              CLS_BS: begin
                if (cur_col != 5'd0) begin
                  col_d   = cur_col - 5'd1;
                  wr_en_d = 1'b1;
                  addr_d  = {cur_row, cur_col - 5'd1};
                  code_d  = BLANK_CODE;
                end
              end
              CLS_FF: begin
                row_d = 5'd0;
                col_d = 5'd0;
              end
              default: ;
            endcase
          end
        end
        CLR_LINE: begin
          wr_en_d = 1'b1;
          addr_d  = {cur_row, clr_idx[4:0]};
          code_d  = BLANK_CODE;
        end
        CLR_SCR: begin
          wr_en_d = 1'b1;
          addr_d  = clr_idx;
          code_d  = BLANK_CODE;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers: cursor, sweep index, write port, pending slot, overrun pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_row    <= 5'd0;
      cur_col    <= 5'd0;
      clr_idx    <= 10'd0;
      wr_en      <= 1'b0;
      wr_addr    <= 10'd0;
      wr_data    <= 8'd0;
      pend_valid <= 1'b0;
      pend_data  <= 8'd0;
      overrun    <= 1'b0;
    end else begin
      cur_row <= row_d;
      cur_col <= col_d;
      clr_idx <= clr_idx_d;
      wr_en   <= wr_en_d;
      wr_addr <= addr_d;
      wr_data <= {4'd0, code_d};
      overrun <= drop;
      if (latch_pend) begin
        pend_valid <= 1'b1;
        pend_data  <= rx_data;
      end else if (proc_pend) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// tb/tb_text_cursor_ctrl.sv - randomized self-checking bench with a screen-level reference model
module tb_text_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_strobe;
  logic [7:0] rx_data;
  logic       clear_req;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] cur_row;
  logic [4:0] cur_col;
  logic       busy;
  logic       overrun;

  always #5 clk = ~clk;

  text_cursor_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .rx_strobe (rx_strobe),
    .rx_data   (rx_data),
    .clear_req (clear_req),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .busy      (busy),
    .overrun   (overrun)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: cursor, expected write list and expected screen image
  int          mrow, mcol, mbusy;
  logic [7:0]  mscreen [0:1023];
  logic [7:0]  ram [0:1023];
  logic [17:0] exp_q [$];
  logic [17:0] act_q [$];
  int          ovr_cnt = 0;
  int          bad_wr = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_w(input int addr, input int code);
    logic [9:0] a;
    logic [7:0] d;
    a = addr[9:0];
    d = code[7:0];
    exp_q.push_back({a, d});
    mscreen[addr] = d;
  endtask

  task automatic model_newline();
    mcol = 0;
    mrow = (mrow == 27) ? 0 : mrow + 1;
    for (int c = 0; c < 32; c++) push_w(mrow * 32 + c, 10);
    mbusy += 32;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int code;
    if ((b >= 8'h30 && b <= 8'h39) || b == 8'h20) begin
      code = (b == 8'h20) ? 10 : int'(b) - 48;
      push_w(mrow * 32 + mcol, code);
      if (mcol == 31) model_newline();
      else mcol++;
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      model_newline();
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        push_w(mrow * 32 + mcol, 10);
      end
    end else if (b == 8'h0C) begin
      mrow = 0;
      mcol = 0;
      for (int a = 0; a < 896; a++) push_w(a, 10);
      mbusy += 896;
    end
  endtask

  function automatic logic is_special(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || b == 8'h20 || b == 8'h0D ||
           b == 8'h0A || b == 8'h08 || b == 8'h0C;
  endfunction

  // Write port monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (wr_en) begin
      act_q.push_back({wr_addr, wr_data});
      ram[wr_addr] = wr_data;
      if (wr_data[7:4] != 4'd0 || wr_addr[9:5] >= 5'd28) bad_wr++;
    end
    if (overrun) ovr_cnt++;
  end

  task automatic wait_idle(output int bc);
    bc = 0;
    while (busy && bc < 3000) begin
      bc++;
      @(negedge clk);
    end
    check_eq("busy_timeout", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_writes(input string tag);
    int bad;
    int n;
    check_eq({tag, "_wr_count"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    bad = 0;
    for (int i = 0; i < n; i++) if (act_q[i] !== exp_q[i]) bad++;
    check_eq({tag, "_wr_seq"}, bad, 0);
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int bc;
    mbusy = 0;
    model_byte(b);
    @(negedge clk);
    rx_strobe = 1'b1;
    rx_data   = b;
    @(negedge clk);
    rx_strobe = 1'b0;
    wait_idle(bc);
    check_eq($sformatf("busy_cyc_%02h", b), bc, mbusy);
    compare_writes($sformatf("byte_%02h", b));
    check_eq($sformatf("row_%02h", b), cur_row, mrow);
    check_eq($sformatf("col_%02h", b), cur_col, mcol);
  endtask

  initial begin
    int bc;
    int o0;
    int bad;
    int r;
    logic [7:0] b;

    for (int i = 0; i < 1024; i++) begin
      ram[i] = 8'hFF;
      mscreen[i] = 8'hFF;
    end
    rst = 1'b0;
    rx_strobe = 1'b0;
    rx_data = 8'h00;
    clear_req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_row", cur_row, 0);
    check_eq("rst_col", cur_col, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // First print lands one cycle after the strobe
    rx_strobe = 1'b1;
    rx_data = 8'h35;
    @(negedge clk);
    rx_strobe = 1'b0;
    check_eq("p5_wr_en", wr_en, 1);
    check_eq("p5_wr_addr", wr_addr, 10'h000);
    check_eq("p5_wr_data", wr_data, 8'h05);
    check_eq("p5_col", cur_col, 1);
    check_eq("p5_row", cur_row, 0);
    repeat (3) @(negedge clk);

    // Screen clear with two bytes arriving during the sweep
    act_q.delete();
    exp_q.delete();
    mrow = 0;
    mcol = 1;
    mbusy = 0;
    o0 = ovr_cnt;
    model_byte(8'h0C);
    model_byte(8'h37);
    rx_strobe = 1'b1;
    rx_data = 8'h0C;
    @(negedge clk);
    rx_strobe = 1'b0;
    bc = 0;
    while (busy && bc < 2000) begin
      bc++;
      rx_strobe = (bc == 10 || bc == 20);
      rx_data = 8'h37;
      @(negedge clk);
    end
    rx_strobe = 1'b0;
    check_eq("ff_busy_cycles", bc, 896);
    @(negedge clk);
    check_eq("pend_wr_en", wr_en, 1);
    check_eq("pend_wr_addr", wr_addr, 10'h000);
    check_eq("pend_wr_data", wr_data, 8'h07);
    repeat (3) @(negedge clk);
    compare_writes("ff7");
    check_eq("ff7_overruns", ovr_cnt - o0, 1);
    check_eq("ff7_row", cur_row, mrow);
    check_eq("ff7_col", cur_col, mcol);

    // 32 prints from home: the last one wraps and clears row 1
    send_byte(8'h0D);
    for (int i = 0; i < 32; i++) send_byte(8'h31);
    check_eq("wrap_row", cur_row, 1);
    check_eq("wrap_col", cur_col, 0);

    // LF from the last row wraps to row 0
    while (mrow != 27) send_byte(8'h0A);
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h33);
    check_eq("r27_col", cur_col, 3);
    send_byte(8'h0A);
    check_eq("lf_wrap_row", cur_row, 0);
    check_eq("lf_wrap_col", cur_col, 0);

    // Backspace at column 0 and at column 4
    send_byte(8'h0D);
    send_byte(8'h08);
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h33);
    send_byte(8'h34);
    send_byte(8'h08);
    check_eq("bs_col", cur_col, 3);

    // clear_req wins over a coincident byte, which is then printed from pending
    send_byte(8'h34);
    mbusy = 0;
    model_byte(8'h0C);
    model_byte(8'h33);
    @(negedge clk);
    clear_req = 1'b1;
    rx_strobe = 1'b1;
    rx_data = 8'h33;
    @(negedge clk);
    clear_req = 1'b0;
    rx_strobe = 1'b0;
    wait_idle(bc);
    check_eq("creq_busy_cycles", bc, mbusy);
    compare_writes("creq");
    check_eq("creq_row", cur_row, mrow);
    check_eq("creq_col", cur_col, mcol);

    // Randomized byte stream against the model
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) b = 8'h30 + 8'($urandom_range(0, 9));
      else if (r < 48) b = 8'h20;
      else if (r < 56) b = 8'h0D;
      else if (r < 70) b = 8'h0A;
      else if (r < 82) b = 8'h08;
      else if (r < 84) b = 8'h0C;
      else begin
        b = 8'($urandom_range(0, 255));
        if (is_special(b)) b = 8'h41;
      end
      send_byte(b);
    end

    bad = 0;
    for (int a = 0; a < 1024; a++) if (ram[a] !== mscreen[a]) bad++;
    check_eq("screen_image", bad, 0);
    check_eq("wr_range", bad_wr, 0);

    // Reset in the middle of a screen clear
    @(negedge clk);
    rx_strobe = 1'b1;
    rx_data = 8'h0C;
    @(negedge clk);
    rx_strobe = 1'b0;
    repeat (99) @(negedge clk);
    check_eq("mid_clr_wr_en", wr_en, 1);
    rst = 1'b0;
    #1;
    check_eq("arst_wr_en", wr_en, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_row", cur_row, 0);
    check_eq("arst_col", cur_col, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    act_q.delete();
    exp_q.delete();
    rx_strobe = 1'b1;
    rx_data = 8'h41;
    @(negedge clk);
    rx_strobe = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("ign_writes", act_q.size(), 0);
    check_eq("ign_row", cur_row, 0);
    check_eq("ign_col", cur_col, 0);
    check_eq("ign_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
